wave_dds: RTL

Direct-digital-synthesis stage that drives the board's 8-bit parallel bus (R-2R DAC pins), the LED and a sync pin with a programmable waveform instead of raw counter bits. A 26-bit phase accumulator advances by a frequency tuning word (FTW) each enabled cycle. The top 8 phase bits are shaped into saw, triangle, square or sine. A new FTW and waveform arrive over a valid/ready handshake and are applied glitch-free at the next phase wrap.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/dds_sine_lut.sv | 33 +++
 rtl/wave_dds.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the wave_dds stage: waveform encodings, the
// quarter-wave sine table and the DAC midpoint.
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_SIN = 2'd3
    } wave_e;

    // Mid-scale code of the 8-bit DAC; the sine swings +/-127 around it.
    localparam logic [7:0] DAC_MID = 8'd128;

    // Quarter-wave magnitude: SIN_QTR[k] = round(127 * sin(pi * k / 128)).
    localparam logic [6:0] SIN_QTR [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

endpackage

// File: rtl/dds_sine_lut.sv
// Combinational 8-bit sine shaper: folds the phase into one quadrant of the
// shared quarter-wave table and restores sign around the DAC midpoint.
module dds_sine_lut
    import dds_pkg::*;
(
    input  logic [7:0] phase_idx,
    output logic [7:0] sample
);

    logic [1:0] quad_s;
    logic [5:0] idx_s;
    logic [6:0] addr_s;
    logic [6:0] mag_s;

    // Quadrant fold: odd quadrants read the table backwards, the lower
    // half-period adds to midpoint, the upper half subtracts.
    always_comb begin
        quad_s = phase_idx[7:6];
        idx_s  = phase_idx[5:0];
        if (quad_s[0]) begin
            addr_s = 7'd64 - {1'b0, idx_s};
        end else begin
            addr_s = {1'b0, idx_s};
        end
        mag_s = SIN_QTR[addr_s];
        if (quad_s[1]) begin
            sample = DAC_MID - {1'b0, mag_s};
        end else begin
            sample = DAC_MID + {1'b0, mag_s};
        end
    end

endmodule

// File: rtl/wave_dds.sv
// Direct-digital-synthesis stage: phase accumulator, FTW/waveform handshake
// with a single pending slot applied at phase wrap, and a registered
// waveform shaper driving the parallel DAC bus.
module wave_dds
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH = 26,
    parameter int OUT_WIDTH = 8   // sine path is built for an 8-bit bus
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic [ACC_WIDTH-1:0] ftw_data,
    input  logic [1:0]           wave_sel,
    output logic [OUT_WIDTH-1:0] dac_out,
    output logic                 sync_out,
    output logic                 wrap_pulse
);

    logic [ACC_WIDTH-1:0] phase_q,    phase_d;
    logic [ACC_WIDTH-1:0] ftw_q,      ftw_d;
    logic [ACC_WIDTH-1:0] pend_ftw_q, pend_ftw_d;
    wave_e                wave_q,     wave_d;
    wave_e                pend_wave_q, pend_wave_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 wrap_q,     wrap_d;
    logic [OUT_WIDTH-1:0] dac_q,      dac_d;

    logic [ACC_WIDTH:0]   sum_s;
    logic                 carry_s;
    logic                 accept_s;
    logic                 apply_s;
    logic [OUT_WIDTH-1:0] phase_idx_s;
    logic [OUT_WIDTH-1:0] sine_s;
    logic [OUT_WIDTH-1:0] shaped_s;

    assign ftw_ready   = ~pend_valid_q;
    assign sync_out    = phase_q[ACC_WIDTH-1];
    assign dac_out     = dac_q;
    assign wrap_pulse  = wrap_q;
    assign phase_idx_s = phase_q[ACC_WIDTH-1 -: OUT_WIDTH];

    dds_sine_lut u_sine_lut (
        .phase_idx (phase_idx_s),
        .sample    (sine_s)
    );

    // Accumulator sum with carry, handshake accept and the apply decision.
    // A stalled oscillator (active FTW of zero) never wraps, so a pending
    // word is taken on the next edge instead. Accept and apply are exclusive
    // because accept needs an empty slot and apply needs a full one, which
    // keeps a word accepted on a wrap edge waiting for the following wrap.
    always_comb begin
        sum_s    = {1'b0, phase_q} + {1'b0, ftw_q};
        carry_s  = sum_s[ACC_WIDTH];
        accept_s = ftw_valid & ~pend_valid_q;
        apply_s  = pend_valid_q &
                   ((enable & carry_s) | (ftw_q == {ACC_WIDTH{1'b0}}));
    end

    // Waveform shaping of the current phase index with the active wave.
    always_comb begin
        shaped_s = phase_idx_s;
        case (wave_q)
            WAVE_SAW: shaped_s = phase_idx_s;
            WAVE_TRI: begin
                if (phase_idx_s[OUT_WIDTH-1]) begin
                    shaped_s = ~{phase_idx_s[OUT_WIDTH-2:0], 1'b0};
                end else begin
                    shaped_s = {phase_idx_s[OUT_WIDTH-2:0], 1'b0};
                end
            end
            WAVE_SQR: begin
                if (phase_idx_s[OUT_WIDTH-1]) begin
                    shaped_s = {OUT_WIDTH{1'b0}};
                end else begin
                    shaped_s = {OUT_WIDTH{1'b1}};
                end
            end
            WAVE_SIN: shaped_s = sine_s;
            default:  shaped_s = phase_idx_s;
        endcase
    end

    // Next-state for phase, wrap flag, DAC sample, active and pending words.
    always_comb begin
        phase_d      = phase_q;
        wrap_d       = 1'b0;
        dac_d        = dac_q;
        ftw_d        = ftw_q;
        wave_d       = wave_q;
        pend_valid_d = pend_valid_q;
        pend_ftw_d   = pend_ftw_q;
        pend_wave_d  = pend_wave_q;

        if (enable) begin
            phase_d = sum_s[ACC_WIDTH-1:0];
            wrap_d  = carry_s;
            dac_d   = shaped_s;
        end else begin
            phase_d = phase_q;
            wrap_d  = 1'b0;
            dac_d   = dac_q;
        end

        if (apply_s) begin
            ftw_d        = pend_ftw_q;
            wave_d       = pend_wave_q;
            pend_valid_d = 1'b0;
        end else if (accept_s) begin
            pend_valid_d = 1'b1;
            pend_ftw_d   = ftw_data;
            pend_wave_d  = wave_e'(wave_sel);
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // State register with synchronous active-low reset; reset also drops
    // anything pending and any transfer offered in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q      <= {ACC_WIDTH{1'b0}};
            ftw_q        <= {ACC_WIDTH{1'b0}};
            wave_q       <= WAVE_SAW;
            pend_valid_q <= 1'b0;
            pend_ftw_q   <= {ACC_WIDTH{1'b0}};
            pend_wave_q  <= WAVE_SAW;
            wrap_q       <= 1'b0;
            dac_q        <= {OUT_WIDTH{1'b0}};
        end else begin
            phase_q      <= phase_d;
            ftw_q        <= ftw_d;
            wave_q       <= wave_d;
            pend_valid_q <= pend_valid_d;
            pend_ftw_q   <= pend_ftw_d;
            pend_wave_q  <= pend_wave_d;
            wrap_q       <= wrap_d;
            dac_q        <= dac_d;
        end
    end

endmodule
